// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: FSM states, ACK levels, R/W bit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Bit position of R/W in the address byte (1 = read).
  localparam int I2C_RW_READ = 0;

endpackage

// File: rtl/i2c_in_filter.sv
// Conditions one asynchronous I2C pad input: 2-FF sync, FILT_N-sample glitch filter, edge pulses.
// Latency: 2 sync cycles + FILT_N filter cycles from pad change to o_lvl change.
// Backpressure: none; free-running per clock.
//
// Ports:
//   clk, rst_n   : system clock, async active-low reset (all stages reset to 1 = bus idle)
//   i_raw        : asynchronous pad level
//   o_lvl        : filtered level
//   o_rise/o_fall: one-cycle pulses when o_lvl goes 0->1 / 1->0
module i2c_in_filter #(
  parameter int FILT_N = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(FILT_N + 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_filt;
  logic          r_prev;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
      r_filt  <= 1'b1;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= i_raw;
      r_sync1 <= r_sync0;
      r_prev  <= r_filt;
      // The filtered level follows only after FILT_N consecutive samples
      // disagree with it; any agreeing sample restarts the count.
      if (r_sync1 != r_filt) begin
        if (r_cnt == CW'(FILT_N - 1)) begin
          r_filt <= r_sync1;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_lvl  = r_filt;
  assign o_rise = r_filt & ~r_prev;
  assign o_fall = ~r_filt & r_prev;

endmodule

// File: rtl/i2c_target_regs.sv
// LM75-style I2C target: first written byte sets a pointer, further writes strobe out, reads fetch rd_data.
// Latency: SDA response on the filtered SCL fall (sync + filter delay); wr_stb on the filtered 8th SCL rise.
// Backpressure: none; no clock stretching, fabric must return rd_data combinationally.
//
// Ports:
//   clk, rst_n       : system clock (>= 8x SCL), async active-low reset
//   scl_i, sda_i     : asynchronous pad inputs
//   sda_oe           : 1 = pull SDA low
//   wr_stb/addr/data : one-cycle write strobe per accepted data byte
//   rd_addr, rd_data : current pointer and the register value at it
//   busy             : high from address match until STOP or master NACK
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h48,
  parameter int         PTR_W    = 3,
  parameter int         FILT_N   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             busy
);

  logic w_scl;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_sda;
  logic w_sda_rise;
  logic w_sda_fall;

  i2c_in_filter #(.FILT_N(FILT_N)) u_scl_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_raw  (scl_i),
    .o_lvl  (w_scl),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  i2c_in_filter #(.FILT_N(FILT_N)) u_sda_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_raw  (sda_i),
    .o_lvl  (w_sda),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  logic w_start;
  logic w_stop;
  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  i2c_state_e       r_state,   w_state_nx;
  logic [3:0]       r_bitcnt,  w_bitcnt_nx;
  logic [6:0]       r_shift,   w_shift_nx;
  logic [7:0]       r_tx,      w_tx_nx;
  logic [PTR_W-1:0] r_ptr,     w_ptr_nx;
  logic             r_sda_oe,  w_oe_nx;
  logic             r_busy,    w_busy_nx;
  logic             r_rw,      w_rw_nx;
  logic             r_wr_stb,  w_stb_nx;
  logic [PTR_W-1:0] r_wr_addr, w_waddr_nx;
  logic [7:0]       r_wr_data, w_wdata_nx;

  // Byte as it stands once the bit on the current SCL rise is shifted in.
  logic [7:0] w_byte;
  assign w_byte = {r_shift, w_sda};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_tx      <= '0;
      r_ptr     <= '0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_rw      <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_bitcnt  <= w_bitcnt_nx;
      r_shift   <= w_shift_nx;
      r_tx      <= w_tx_nx;
      r_ptr     <= w_ptr_nx;
      r_sda_oe  <= w_oe_nx;
      r_busy    <= w_busy_nx;
      r_rw      <= w_rw_nx;
      r_wr_stb  <= w_stb_nx;
      r_wr_addr <= w_waddr_nx;
      r_wr_data <= w_wdata_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_bitcnt_nx = r_bitcnt;
    w_shift_nx  = r_shift;
    w_tx_nx     = r_tx;
    w_ptr_nx    = r_ptr;
    w_oe_nx     = r_sda_oe;
    w_busy_nx   = r_busy;
    w_rw_nx     = r_rw;
    w_stb_nx    = 1'b0;
    w_waddr_nx  = r_wr_addr;
    w_wdata_nx  = r_wr_data;

    // Post-strobe pointer advance is committed even if START/STOP follows.
    if (r_wr_stb) begin
      w_ptr_nx = r_ptr + 1'b1;
    end

    if (w_start) begin
      w_state_nx  = ADDR;
      w_bitcnt_nx = '0;
      w_oe_nx     = 1'b0;
    end else if (w_stop) begin
      w_state_nx  = IDLE;
      w_bitcnt_nx = '0;
      w_oe_nx     = 1'b0;
      w_busy_nx   = 1'b0;
    end else begin
      unique case (r_state)
        ADDR, PTR, WDATA: begin
          if (w_scl_rise) begin
            w_shift_nx  = w_byte[6:0];
            w_bitcnt_nx = r_bitcnt + 1'b1;
            if (r_bitcnt == 4'd7) begin
              w_bitcnt_nx = '0;
              if (r_state == ADDR) begin
                if (w_byte[7:1] == I2C_ADDR) begin
                  w_state_nx = ADDR_ACK;
                  w_busy_nx  = 1'b1;
                  w_rw_nx    = w_byte[I2C_RW_READ];
                end else begin
                  w_state_nx = WAIT_STOP;
                  w_busy_nx  = 1'b0;
                end
              end else if (r_state == PTR) begin
                w_ptr_nx   = w_byte[PTR_W-1:0];
                w_state_nx = PTR_ACK;
              end else begin
                w_stb_nx   = 1'b1;
                w_waddr_nx = r_ptr;
                w_wdata_nx = w_byte;
                w_state_nx = WDATA_ACK;
              end
            end
          end
        end

        // Our own sda_oe marks the ACK phase: first fall pulls SDA low,
        // the fall after the 9th clock releases it and moves on.
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_oe_nx = 1'b1;
            end else begin
              w_oe_nx     = 1'b0;
              w_bitcnt_nx = '0;
              if (r_state == ADDR_ACK && r_rw) begin
                w_tx_nx    = rd_data;
                w_oe_nx    = ~rd_data[7];
                w_ptr_nx   = r_ptr + 1'b1;
                w_state_nx = RDATA;
              end else if (r_state == ADDR_ACK) begin
                w_state_nx = PTR;
              end else begin
                w_state_nx = WDATA;
              end
            end
          end
        end

        // r_bitcnt counts master sampling rises; bit 7 is already on the line.
        RDATA: begin
          if (w_scl_rise) begin
            w_bitcnt_nx = r_bitcnt + 1'b1;
          end else if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_oe_nx     = 1'b0;
              w_bitcnt_nx = '0;
              w_state_nx  = RDATA_ACK;
            end else begin
              w_oe_nx = ~r_tx[6];
              w_tx_nx = {r_tx[6:0], 1'b0};
            end
          end
        end

        // r_bitcnt = 1 records a master ACK awaiting the next fall.
        RDATA_ACK: begin
          if (w_scl_rise) begin
            if (w_sda == NACK) begin
              w_state_nx = WAIT_STOP;
              w_busy_nx  = 1'b0;
            end else begin
              w_bitcnt_nx = 4'd1;
            end
          end else if (w_scl_fall && r_bitcnt == 4'd1) begin
            w_tx_nx     = rd_data;
            w_oe_nx     = ~rd_data[7];
            w_ptr_nx    = r_ptr + 1'b1;
            w_bitcnt_nx = '0;
            w_state_nx  = RDATA;
          end
        end

        default: begin
          // IDLE and WAIT_STOP hold SDA released until START/STOP.
          w_oe_nx = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe  = r_sda_oe;
  assign wr_stb  = r_wr_stb;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign rd_addr = r_ptr;
  assign busy    = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic       clk;
  logic       rst_n;
  logic       scl_m;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic       wr_stb;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  assign sda_line = sda_m & ~sda_oe;
  assign rd_data  = 8'h10 | {5'd0, rd_addr};

  i2c_target_regs dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl_i   (scl_m),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitors: log every strobe, count cycles with SDA pulled and non-idle state.
  int         stb_n = 0;
  int         oe_cnt = 0;
  int         nonidle_cnt = 0;
  logic [2:0] stb_addr [16];
  logic [7:0] stb_data [16];

  always @(negedge clk) begin
    if (wr_stb) begin
      stb_addr[stb_n[3:0]] = wr_addr;
      stb_data[stb_n[3:0]] = wr_data;
      stb_n = stb_n + 1;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
    if (dut.r_state != IDLE) nonidle_cnt = nonidle_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Also usable as a repeated START from SCL low.
  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_line; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(mack);
  endtask

  logic       ack;
  logic [7:0] rb;
  int         base;
  int         oe_base;
  int         ni_base;

  initial begin
    rst_n = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(3);
    chk("rst_sda_oe",  {31'd0, sda_oe}, 32'd0);
    chk("rst_wr_stb",  {31'd0, wr_stb}, 32'd0);
    chk("rst_busy",    {31'd0, busy},   32'd0);
    chk("rst_rd_addr", {29'd0, rd_addr}, 32'd0);
    chk("rst_wr_addr", {29'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    rst_n = 1'b1;
    wait_clk(10);

    // Write: pointer 2, data A5, 3C.
    base = stb_n;
    i2c_start();
    write_byte(8'h90, ack); chk("wr_ack_addr", {31'd0, ack}, 32'd0);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    write_byte(8'h02, ack); chk("wr_ack_ptr", {31'd0, ack}, 32'd0);
    write_byte(8'hA5, ack); chk("wr_ack_d0", {31'd0, ack}, 32'd0);
    write_byte(8'h3C, ack); chk("wr_ack_d1", {31'd0, ack}, 32'd0);
    i2c_stop();
    wait_clk(5);
    chk("wr_stb_count", 32'(stb_n - base), 32'd2);
    chk("wr_stb0_addr", {29'd0, stb_addr[base[3:0]]}, 32'd2);
    chk("wr_stb0_data", {24'd0, stb_data[base[3:0]]}, 32'hA5);
    chk("wr_stb1_addr", {29'd0, stb_addr[base[3:0] + 4'd1]}, 32'd3);
    chk("wr_stb1_data", {24'd0, stb_data[base[3:0] + 4'd1]}, 32'h3C);
    chk("wr_rd_addr",   {29'd0, rd_addr}, 32'd4);
    chk("wr_busy_stop", {31'd0, busy}, 32'd0);

    // Read: pointer 6, repeated START, three bytes with wrap.
    base = stb_n;
    i2c_start();
    write_byte(8'h90, ack); chk("rd_ack_addr_w", {31'd0, ack}, 32'd0);
    write_byte(8'h06, ack); chk("rd_ack_ptr", {31'd0, ack}, 32'd0);
    i2c_start();
    write_byte(8'h91, ack); chk("rd_ack_addr_r", {31'd0, ack}, 32'd0);
    read_byte(rb, ACK);  chk("rd_byte0", {24'd0, rb}, 32'h16);
    read_byte(rb, ACK);  chk("rd_byte1", {24'd0, rb}, 32'h17);
    read_byte(rb, NACK); chk("rd_byte2", {24'd0, rb}, 32'h10);
    wait_clk(5);
    chk("rd_busy_nack", {31'd0, busy}, 32'd0);
    chk("rd_sda_rel",   {31'd0, sda_oe}, 32'd0);
    i2c_stop();
    wait_clk(5);
    chk("rd_no_stb",  32'(stb_n - base), 32'd0);
    chk("rd_rd_addr", {29'd0, rd_addr}, 32'd1);

    // Address mismatch.
    base = stb_n;
    oe_base = oe_cnt;
    i2c_start();
    write_byte(8'h92, ack); chk("mm_nack_addr", {31'd0, ack}, 32'd1);
    write_byte(8'h01, ack); chk("mm_nack_data", {31'd0, ack}, 32'd1);
    chk("mm_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    wait_clk(5);
    chk("mm_oe_never", 32'(oe_cnt - oe_base), 32'd0);
    chk("mm_no_stb",   32'(stb_n - base), 32'd0);
    chk("mm_rd_addr",  {29'd0, rd_addr}, 32'd1);

    // Abort mid data byte.
    base = stb_n;
    i2c_start();
    write_byte(8'h90, ack); chk("ab_ack_addr", {31'd0, ack}, 32'd0);
    write_byte(8'h05, ack); chk("ab_ack_ptr", {31'd0, ack}, 32'd0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    wait_clk(5);
    chk("ab_no_stb",  32'(stb_n - base), 32'd0);
    chk("ab_rd_addr", {29'd0, rd_addr}, 32'd5);
    chk("ab_state",   32'(dut.r_state), 32'(IDLE));
    chk("ab_sda_oe",  {31'd0, sda_oe}, 32'd0);
    chk("ab_busy",    {31'd0, busy}, 32'd0);

    // Glitch: 2-cycle SDA low pulse with SCL high.
    wait_clk(10);
    ni_base = nonidle_cnt;
    sda_m = 1'b0;
    wait_clk(2);
    sda_m = 1'b1;
    wait_clk(20);
    chk("gl_no_start", 32'(nonidle_cnt - ni_base), 32'd0);
    chk("gl_busy",     {31'd0, busy}, 32'd0);

    // Reset during the address ACK low phase.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(8'h90 >> i);
    chk("rs_ack_driven", {31'd0, sda_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_oe_async", {31'd0, sda_oe}, 32'd0);
    chk("rs_busy",     {31'd0, busy}, 32'd0);
    wait_clk(2);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
    chk("rs_rd_addr", {29'd0, rd_addr}, 32'd0);
    rst_n = 1'b1;
    wait_clk(10);
    base = stb_n;
    i2c_start();
    write_byte(8'h90, ack); chk("rs_ack_addr", {31'd0, ack}, 32'd0);
    write_byte(8'h01, ack); chk("rs_ack_ptr", {31'd0, ack}, 32'd0);
    write_byte(8'h77, ack); chk("rs_ack_d0", {31'd0, ack}, 32'd0);
    i2c_stop();
    wait_clk(5);
    chk("rs_stb_count", 32'(stb_n - base), 32'd1);
    chk("rs_stb_addr",  {29'd0, stb_addr[base[3:0]]}, 32'd1);
    chk("rs_stb_data",  {24'd0, stb_data[base[3:0]]}, 32'h77);
    chk("rs_rd_addr2",  {29'd0, rd_addr}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
